uart_cpld_ctrl: RTL and testbench

UART_CPLD_CTRL -- requirements
Module: uart_cpld_ctrl

---
 rtl/uart_cpld_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_uart_cpld_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cpld_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cpld_ctrl
// Function : Bus-to-CPLD UART bridge. Turns single-byte loads/stores on a
//            valid/ready request port into rdn/wrn strobe sequences on the
//            shared CPLD data bus, with a one-cycle response pulse.
//            Optional RX prefetch FIFO enabled by `define UART_RX_PREFETCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cpld_ctrl #(
    parameter int PULSE_CYCLES  = 3,
    parameter int SETUP_CYCLES  = 1,
    parameter int RX_FIFO_DEPTH = 4   // power of two, at least 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       uart_rdn,
    output logic       uart_wrn,
    input  logic       uart_dataready,
    input  logic       uart_tbre,
    input  logic       uart_tsre,
    input  logic [7:0] uart_data_i,
    output logic [7:0] uart_data_o,
    output logic       uart_data_oe
);

    localparam logic [2:0] c_addr_data   = 3'd0;
    localparam logic [2:0] c_addr_status = 3'd5;
    localparam logic [7:0] c_pulse_last  = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] c_setup_last  = 8'(SETUP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_PULSE   = 3'd1,
        WR_WAIT_TX = 3'd2,
        WR_SETUP   = 3'd3,
        WR_PULSE   = 3'd4,
        WR_HOLD    = 3'd5,
        RESP       = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rdy_meta_q, rdy_meta_d, rdy_sync_q, rdy_sync_d;
    logic        tbre_meta_q, tbre_meta_d, tbre_sync_q, tbre_sync_d;
    logic        tsre_meta_q, tsre_meta_d, tsre_sync_q, tsre_sync_d;
    logic        tx_busy_q, tx_busy_d;
    logic        tbre_seen_q, tbre_seen_d;
    logic [7:0]  data_q, data_d;
    logic        rdn_q, rdn_d, wrn_q, wrn_d, oe_q, oe_d;
    logic [7:0]  dout_q, dout_d;
    logic        resp_valid_q, resp_valid_d;
    logic [7:0]  resp_rdata_q, resp_rdata_d;
    logic        rx_avail;
    logic        wr_pulse_enter;

`ifdef UART_RX_PREFETCH_EN
    localparam int                 c_ptr_w     = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
    localparam logic [c_ptr_w:0]   c_fill_full = (c_ptr_w + 1)'(RX_FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_fill_one  = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);

    logic [7:0]         fifo_mem_q [RX_FIFO_DEPTH];
    logic [7:0]         fifo_mem_d [RX_FIFO_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w:0]   fill_q, fill_d;
    logic               fifo_empty, fifo_full, fifo_push, fifo_pop;

    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == c_fill_full);
    assign rx_avail   = !fifo_empty;
`else
    assign rx_avail   = rdy_sync_q;
`endif

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign uart_rdn     = rdn_q;
    assign uart_wrn     = wrn_q;
    assign uart_data_o  = dout_q;
    assign uart_data_oe = oe_q;

    // Sequencer next-state, strobe shaping and TX-busy tracking
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        data_d         = data_q;
        dout_d         = dout_q;
        tx_busy_d      = tx_busy_q;
        tbre_seen_d    = tbre_seen_q;
        resp_valid_d   = 1'b0;
        resp_rdata_d   = 8'h00;
        wr_pulse_enter = 1'b0;
        rdy_meta_d     = uart_dataready;
        rdy_sync_d     = rdy_meta_q;
        tbre_meta_d    = uart_tbre;
        tbre_sync_d    = tbre_meta_q;
        tsre_meta_d    = uart_tsre;
        tsre_sync_d    = tsre_meta_q;
`ifdef UART_RX_PREFETCH_EN
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (req_valid) begin
                    // Anything not explicitly handled below answers 8'h00
                    data_d  = 8'h00;
                    state_d = RESP;
                    if (req_addr == c_addr_data && req_we) begin
                        dout_d  = req_wdata;
                        state_d = WR_WAIT_TX;
                    end else if (req_addr == c_addr_data) begin
`ifdef UART_RX_PREFETCH_EN
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            data_d   = fifo_mem_q[rd_ptr_q];
                        end
`else
                        if (rx_avail) begin
                            state_d = RD_PULSE;
                        end
`endif
                    end else if (req_addr == c_addr_status && !req_we) begin
                        data_d = {2'b00, !tx_busy_q, 4'b0000, rx_avail};
                    end
                end
`ifdef UART_RX_PREFETCH_EN
                // Prefetch only when the bus is quiet so requests are never starved
                else if (!fifo_full && rdy_sync_q) begin
                    state_d = RD_PULSE;
                end
`endif
            end

            RD_PULSE: begin
                if (cnt_q == c_pulse_last) begin
                    cnt_d = 8'd0;
`ifdef UART_RX_PREFETCH_EN
                    fifo_push = 1'b1;
                    state_d   = IDLE;
`else
                    data_d    = uart_data_i;
                    state_d   = RESP;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            WR_WAIT_TX: begin
                if (!tx_busy_q) begin
                    cnt_d   = 8'd0;
                    state_d = WR_SETUP;
                end
            end

            WR_SETUP: begin
                if (cnt_q == c_setup_last) begin
                    cnt_d          = 8'd0;
                    wr_pulse_enter = 1'b1;
                    state_d        = WR_PULSE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            WR_PULSE: begin
                if (cnt_q == c_pulse_last) begin
                    cnt_d   = 8'd0;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            WR_HOLD: begin
                if (cnt_q == c_setup_last) begin
                    cnt_d   = 8'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RESP: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = data_q;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes follow the next state so they line up exactly with it
        rdn_d = (state_d != RD_PULSE);
        wrn_d = (state_d != WR_PULSE);
        oe_d  = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);

        // Busy until the CPLD reports holding buffer empty, then shifter empty
        if (wr_pulse_enter) begin
            tx_busy_d   = 1'b1;
            tbre_seen_d = 1'b0;
        end else if (tx_busy_q) begin
            if (!tbre_seen_q) begin
                if (tbre_sync_q) begin
                    tbre_seen_d = 1'b1;
                end
            end else if (tsre_sync_q) begin
                tx_busy_d   = 1'b0;
                tbre_seen_d = 1'b0;
            end
        end
    end

`ifdef UART_RX_PREFETCH_EN
    // Prefetch FIFO pointer/fill update; simultaneous push and pop keeps the fill
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        if (fifo_push) begin
            fifo_mem_d[wr_ptr_q] = uart_data_i;
            wr_ptr_d             = wr_ptr_q + c_ptr_one;
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        case ({fifo_push, fifo_pop})
            2'b10:   fill_d = fill_q + c_fill_one;
            2'b01:   fill_d = fill_q - c_fill_one;
            default: fill_d = fill_q;
        endcase
    end
`endif

    // State and registered outputs; reset drops any strobe in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            rdy_meta_q   <= 1'b0;
            rdy_sync_q   <= 1'b0;
            tbre_meta_q  <= 1'b0;
            tbre_sync_q  <= 1'b0;
            tsre_meta_q  <= 1'b0;
            tsre_sync_q  <= 1'b0;
            tx_busy_q    <= 1'b0;
            tbre_seen_q  <= 1'b0;
            data_q       <= 8'h00;
            rdn_q        <= 1'b1;
            wrn_q        <= 1'b1;
            oe_q         <= 1'b0;
            dout_q       <= 8'h00;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 8'h00;
`ifdef UART_RX_PREFETCH_EN
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rdy_meta_q   <= rdy_meta_d;
            rdy_sync_q   <= rdy_sync_d;
            tbre_meta_q  <= tbre_meta_d;
            tbre_sync_q  <= tbre_sync_d;
            tsre_meta_q  <= tsre_meta_d;
            tsre_sync_q  <= tsre_sync_d;
            tx_busy_q    <= tx_busy_d;
            tbre_seen_q  <= tbre_seen_d;
            data_q       <= data_d;
            rdn_q        <= rdn_d;
            wrn_q        <= wrn_d;
            oe_q         <= oe_d;
            dout_q       <= dout_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef UART_RX_PREFETCH_EN
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
`endif
        end
`ifdef UART_RX_PREFETCH_EN
        fifo_mem_q <= fifo_mem_d;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cpld_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cpld_ctrl
// Function : Self-checking bench for uart_cpld_ctrl: directed vector table plus
//            hand-written store-stall, mid-strobe reset and prefetch sequences.
//            A small CPLD model serves offered RX bytes on uart_rdn strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cpld_ctrl;

    localparam int c_timeout = 60;
`ifdef UART_RX_PREFETCH_EN
    localparam int c_rd_lat = 2;
    localparam int c_rd_lo  = 0;
`else
    localparam int c_rd_lat = 5;
    localparam int c_rd_lo  = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [2:0] req_addr = 3'd0;
    logic [7:0] req_wdata = 8'h00;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       uart_rdn;
    logic       uart_wrn;
    logic       uart_dataready;
    logic       uart_tbre = 1'b1;
    logic       uart_tsre = 1'b1;
    logic [7:0] uart_data_i;
    logic [7:0] uart_data_o;
    logic       uart_data_oe;

    uart_cpld_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .uart_rdn       (uart_rdn),
        .uart_wrn       (uart_wrn),
        .uart_dataready (uart_dataready),
        .uart_tbre      (uart_tbre),
        .uart_tsre      (uart_tsre),
        .uart_data_i    (uart_data_i),
        .uart_data_o    (uart_data_o),
        .uart_data_oe   (uart_data_oe)
    );

    always #5 clk = ~clk;

    // CPLD RX model: dataready drops as soon as rdn falls, next byte after rdn rises
    logic [7:0] offer_mem [16];
    int         offer_cnt = 0;
    int         taken_cnt = 0;
    bit         rd_active = 1'b0;

    assign uart_dataready = (offer_cnt > taken_cnt) && !rd_active;
    assign uart_data_i    = offer_mem[taken_cnt[3:0]];

    always @(uart_rdn) begin
        if (uart_rdn == 1'b0 && rst) begin
            rd_active = 1'b1;
        end else if (uart_rdn == 1'b1 && rd_active) begin
            rd_active = 1'b0;
            taken_cnt = taken_cnt + 1;
        end
    end

    int overlap_cnt = 0;
    always @(negedge clk) begin
        if (rst && !uart_rdn && !uart_wrn) overlap_cnt++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Results of the most recent run_req
    logic [7:0] r_rdata;
    int r_lat, r_rd, r_wr, r_oe, r_first_oe, r_first_wr, r_dout_bad;

    // Issue one request (call at a negedge) and observe it through its response
    task automatic run_req(input logic we, input logic [2:0] addr, input logic [7:0] wd);
        int guard;
        r_rd = 0; r_wr = 0; r_oe = 0; r_first_oe = -1; r_first_wr = -1; r_dout_bad = 0;
        req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < c_timeout) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready", int'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
        r_lat = 1;
        while (!resp_valid && r_lat < c_timeout) begin
            if (!uart_rdn) r_rd++;
            if (!uart_wrn) begin
                r_wr++;
                if (r_first_wr < 0) r_first_wr = r_lat;
                if (uart_data_o != wd) r_dout_bad++;
            end
            if (uart_data_oe) begin
                r_oe++;
                if (r_first_oe < 0) r_first_oe = r_lat;
            end
            @(negedge clk);
            r_lat++;
        end
        r_rdata = resp_rdata;
        @(negedge clk);
        check("resp_single_pulse", int'(resp_valid), 0);
    endtask

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic       offer;
        logic [7:0] obyte;
        logic [7:0] exp_rdata;
        int         exp_lat;
        int         exp_rd;
        int         exp_wr;
        int         exp_oe;
    } vec_t;

    localparam int c_nvec = 11;
    vec_t vecs [c_nvec];

    initial begin
        int guard;
        int bad;
        int base;

        //            we    addr   wdata  offer obyte  rdata  lat       rd       wr oe
        vecs[0]  = '{1'b0, 3'd5, 8'h00, 1'b1, 8'h77, 8'h21, 2,        0,       0, 0};
        vecs[1]  = '{1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h77, c_rd_lat, c_rd_lo, 0, 0};
        vecs[2]  = '{1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 2,        0,       0, 0};
        vecs[3]  = '{1'b0, 3'd5, 8'h00, 1'b0, 8'h00, 8'h20, 2,        0,       0, 0};
        vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h5A, 8'h5A, c_rd_lat, c_rd_lo, 0, 0};
        vecs[5]  = '{1'b1, 3'd0, 8'h41, 1'b0, 8'h00, 8'h00, 8,        0,       3, 5};
        vecs[6]  = '{1'b1, 3'd5, 8'h99, 1'b0, 8'h00, 8'h00, 2,        0,       0, 0};
        vecs[7]  = '{1'b0, 3'd3, 8'h00, 1'b0, 8'h00, 8'h00, 2,        0,       0, 0};
        vecs[8]  = '{1'b1, 3'd7, 8'hEE, 1'b0, 8'h00, 8'h00, 2,        0,       0, 0};
        vecs[9]  = '{1'b1, 3'd0, 8'hA5, 1'b0, 8'h00, 8'h00, 8,        0,       3, 5};
        vecs[10] = '{1'b0, 3'd5, 8'h00, 1'b0, 8'h00, 8'h20, 2,        0,       0, 0};

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready",  int'(req_ready),    1);
        check("rst_rdn",        int'(uart_rdn),     1);
        check("rst_wrn",        int'(uart_wrn),     1);
        check("rst_oe",         int'(uart_data_oe), 0);
        check("rst_data_o",     int'(uart_data_o),  0);
        check("rst_resp_valid", int'(resp_valid),   0);
        check("rst_resp_rdata", int'(resp_rdata),   0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Directed vector table
        for (int i = 0; i < c_nvec; i++) begin
            if (vecs[i].offer) begin
                offer_mem[offer_cnt[3:0]] = vecs[i].obyte;
                offer_cnt = offer_cnt + 1;
            end
            repeat (12) @(negedge clk);
            run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            check($sformatf("v%0d_rdata", i),    int'(r_rdata), int'(vecs[i].exp_rdata));
            check($sformatf("v%0d_latency", i),  r_lat,         vecs[i].exp_lat);
            check($sformatf("v%0d_rdn_low", i),  r_rd,          vecs[i].exp_rd);
            check($sformatf("v%0d_wrn_low", i),  r_wr,          vecs[i].exp_wr);
            check($sformatf("v%0d_oe_high", i),  r_oe,          vecs[i].exp_oe);
            check($sformatf("v%0d_data_o", i),   r_dout_bad,    0);
        end

        // Store timing window, then a second store stalled by TX busy
        repeat (6) @(negedge clk);
        uart_tbre = 1'b0;
        uart_tsre = 1'b0;
        repeat (4) @(negedge clk);
        run_req(1'b1, 3'd0, 8'h41);
        check("st1_oe_cycles",  r_oe,                    5);
        check("st1_wrn_cycles", r_wr,                    3);
        check("st1_wrn_offset", r_first_wr - r_first_oe, 1);
        check("st1_latency",    r_lat,                   8);
        check("st1_data_o",     r_dout_bad,              0);

        req_we = 1'b1; req_addr = 3'd0; req_wdata = 8'h42; req_valid = 1'b1;
        check("st2_ready", int'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
        bad = 0;
        repeat (8) begin
            if (uart_data_oe || !uart_wrn || resp_valid) bad++;
            @(negedge clk);
        end
        check("st2_stall_idle", bad, 0);
        uart_tsre = 1'b1;
        bad = 0;
        repeat (8) begin
            if (uart_data_oe || !uart_wrn || resp_valid) bad++;
            @(negedge clk);
        end
        check("st2_stall_tsre_only", bad, 0);
        uart_tsre = 1'b0;
        uart_tbre = 1'b1;
        bad = 0;
        repeat (8) begin
            if (uart_data_oe || !uart_wrn || resp_valid) bad++;
            @(negedge clk);
        end
        check("st2_stall_tbre_only", bad, 0);
        uart_tsre = 1'b1;
        guard = 0;
        while (!uart_data_oe && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check("st2_release", int'(uart_data_oe), 1);
        r_wr = 0;
        bad = 0;
        guard = 0;
        while (!resp_valid && guard < 30) begin
            if (!uart_wrn) begin
                r_wr++;
                if (uart_data_o != 8'h42) bad++;
            end
            @(negedge clk);
            guard++;
        end
        check("st2_resp", int'(resp_valid), 1);
        check("st2_wrn_cycles", r_wr, 3);
        check("st2_data_o", bad, 0);

        // Reset during the write pulse
        repeat (8) @(negedge clk);
        req_we = 1'b1; req_addr = 3'd0; req_wdata = 8'h3C; req_valid = 1'b1;
        check("rstw_ready", int'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (uart_wrn && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check("rstw_in_pulse", int'(uart_wrn), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rstw_wrn", int'(uart_wrn),     1);
        check("rstw_oe",  int'(uart_data_oe), 0);
        check("rstw_rdn", int'(uart_rdn),     1);
        rst = 1'b1;
        bad = 0;
        repeat (10) begin
            if (resp_valid) bad++;
            @(negedge clk);
        end
        check("rstw_no_resp", bad, 0);
        check("rstw_idle", int'(req_ready), 1);

`ifdef UART_RX_PREFETCH_EN
        // Prefetch: five bytes offered, four fit, loads drain them in order
        repeat (6) @(negedge clk);
        base = taken_cnt;
        for (int k = 0; k < 5; k++) begin
            offer_mem[offer_cnt[3:0]] = 8'hC0 + 8'(k);
            offer_cnt = offer_cnt + 1;
        end
        repeat (40) @(negedge clk);
        check("pf_fill_stops_at_full", taken_cnt - base, 4);
        for (int k = 0; k < 5; k++) begin
            run_req(1'b0, 3'd0, 8'h00);
            check($sformatf("pf_load%0d_rdata", k), int'(r_rdata), 'hC0 + k);
            check($sformatf("pf_load%0d_lat", k),   r_lat,         2);
            repeat (12) @(negedge clk);
        end
        check("pf_all_taken", taken_cnt - base, 5);
`else
        base = 0;
`endif

        check("rd_wr_overlap", overlap_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
